// File: rtl/sram_like_responder_if.sv
// sram_like_responder_if: initiator/responder bus for the SRAM-like request/response handshake.
interface sram_like_responder_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    modport master (output req, wr, size, wstrb, addr, wdata, input addr_ok, data_ok, rdata);
    modport slave  (input req, wr, size, wstrb, addr, wdata, output addr_ok, data_ok, rdata);
endinterface

// File: rtl/sram_like_responder.sv
// sram_like_responder: word memory answering accepted requests in order after a fixed DELAY,
// with up to DEPTH requests outstanding.
module sram_like_responder #(
    parameter int MEM_AW = 10,
    parameter int DELAY  = 2,
    parameter int DEPTH  = 2
) (
    input logic clk,
    input logic reset,
    sram_like_responder_if.slave bus
);
    logic [31:0]       mem [2**MEM_AW];
    logic              q_wr   [4];
    logic [31:0]       q_data [4];
    logic [3:0]        q_cnt  [4];
    logic [1:0]        head, tail;
    logic [2:0]        count;
    logic              acc, pop;
    logic [MEM_AW-1:0] idx;
    logic              unused_bits;
    assign idx         = bus.addr[MEM_AW+1:2];
    assign acc         = bus.req & ~reset & (count < 3'(DEPTH));
    assign pop         = ~reset & (count != 3'd0) & (q_cnt[head] == 4'd0);
    assign bus.addr_ok = acc;
    assign bus.data_ok = pop;
    assign bus.rdata   = (pop & ~q_wr[head]) ? q_data[head] : 32'd0;
    assign unused_bits = ^{bus.size, bus.addr[31:MEM_AW+2], bus.addr[1:0]};
    always_ff @(posedge clk) begin
        if (acc && bus.wr)
            for (int b = 0; b < 4; b++)
                if (bus.wstrb[b]) mem[idx][8*b +: 8] <= bus.wdata[8*b +: 8];
    end
    // every entry counts down together so the head is already due when its predecessor pops
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            q_cnt[i] <= (q_cnt[i] == 4'd0) ? 4'd0 : q_cnt[i] - 4'd1;
        if (reset) begin
            head  <= 2'd0;
            tail  <= 2'd0;
            count <= 3'd0;
        end else begin
            if (acc) begin
                q_wr[tail]   <= bus.wr;
                q_data[tail] <= bus.wr ? 32'd0 : mem[idx];
                q_cnt[tail]  <= 4'(DELAY - 1);
                tail         <= (tail == 2'(DEPTH - 1)) ? 2'd0 : tail + 2'd1;
            end
            if (pop) head <= (head == 2'(DEPTH - 1)) ? 2'd0 : head + 2'd1;
            count <= count + 3'(acc) - 3'(pop);
        end
    end
endmodule

// File: tb/tb_sram_like_responder.sv
// tb_sram_like_responder: directed cycle-by-cycle checks of handshake, latency, byte strobes,
// index wrap, backpressure and reset flush for MEM_AW=10, DELAY=2, DEPTH=2.
module tb_sram_like_responder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    sram_like_responder_if bus ();
    sram_like_responder #(.MEM_AW(10), .DELAY(2), .DEPTH(2)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic drive(logic r, logic w, logic [3:0] s, logic [31:0] a, logic [31:0] d);
        bus.req = r;
        bus.wr = w;
        bus.size = 2'd2;
        bus.wstrb = s;
        bus.addr = a;
        bus.wdata = d;
    endtask
    task automatic idle();
        drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask
    task automatic cyc(string tag, logic ea, logic ed, logic [31:0] er);
        @(negedge clk);
        check({tag, ".addr_ok"}, {31'd0, bus.addr_ok}, {31'd0, ea});
        check({tag, ".data_ok"}, {31'd0, bus.data_ok}, {31'd0, ed});
        check({tag, ".rdata"}, bus.rdata, er);
        @(posedge clk);
        #1;
    endtask
    task automatic write_word(string tag, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        drive(1'b1, 1'b1, s, a, d);
        cyc(tag, 1'b1, 1'b0, 32'h0);
        idle();
        cyc(tag, 1'b0, 1'b0, 32'h0);
        cyc(tag, 1'b0, 1'b1, 32'h0);
    endtask
    task automatic read_word(string tag, logic [31:0] a, logic [31:0] exp);
        drive(1'b1, 1'b0, 4'hF, a, 32'hFFFF_FFFF);
        cyc(tag, 1'b1, 1'b0, 32'h0);
        idle();
        cyc(tag, 1'b0, 1'b0, 32'h0);
        cyc(tag, 1'b0, 1'b1, exp);
    endtask
    initial begin
        drive(1'b1, 1'b1, 4'hF, 32'h10, 32'h5555_5555);
        reset = 1'b1;
        cyc("rst0", 1'b0, 1'b0, 32'h0);
        cyc("rst1", 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        write_word("wr_full", 32'h10, 32'hDEAD_BEEF, 4'hF);
        read_word("rd_full", 32'h10, 32'hDEAD_BEEF);
        write_word("wr_lane1", 32'h10, 32'h0000_AB00, 4'b0010);
        read_word("rd_lane1", 32'h10, 32'hDEAD_ABEF);
        write_word("wr_wrap", 32'h1004, 32'h1234_5678, 4'hF);
        read_word("rd_wrap", 32'h0004, 32'h1234_5678);
        write_word("wr_20", 32'h20, 32'h1111_1111, 4'hF);
        write_word("wr_24", 32'h24, 32'h2222_2222, 4'hF);
        write_word("wr_28", 32'h28, 32'h3333_3333, 4'hF);
        write_word("wr_nostrb", 32'h24, 32'hFFFF_FFFF, 4'h0);
        read_word("rd_nostrb", 32'h24, 32'h2222_2222);
        // req held high: third read stalls while two are outstanding, then is accepted
        drive(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        cyc("bp_c0", 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
        cyc("bp_c1", 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 4'h0, 32'h28, 32'h0);
        cyc("bp_c2", 1'b0, 1'b1, 32'h1111_1111);
        cyc("bp_c3", 1'b1, 1'b1, 32'h2222_2222);
        idle();
        cyc("bp_c4", 1'b0, 1'b0, 32'h0);
        cyc("bp_c5", 1'b0, 1'b1, 32'h3333_3333);
        cyc("bp_c6", 1'b0, 1'b0, 32'h0);
        // reset in cycle 1 discards outstanding reads; a fresh read afterwards answers normally
        drive(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
        cyc("rf_c0", 1'b1, 1'b0, 32'h0);
        drive(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
        reset = 1'b1;
        cyc("rf_c1", 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        drive(1'b1, 1'b0, 4'h0, 32'h24, 32'h0);
        cyc("rf_c2", 1'b1, 1'b0, 32'h0);
        idle();
        cyc("rf_c3", 1'b0, 1'b0, 32'h0);
        cyc("rf_c4", 1'b0, 1'b1, 32'h2222_2222);
        cyc("rf_c5", 1'b0, 1'b0, 32'h0);
        cyc("rf_c6", 1'b0, 1'b0, 32'h0);
        // accepted write survives a reset that discards its response
        drive(1'b1, 1'b1, 4'hF, 32'h30, 32'hCAFE_F00D);
        cyc("rw_wr", 1'b1, 1'b0, 32'h0);
        idle();
        reset = 1'b1;
        cyc("rw_rst", 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        cyc("rw_post0", 1'b0, 1'b0, 32'h0);
        cyc("rw_post1", 1'b0, 1'b0, 32'h0);
        read_word("rw_rd", 32'h30, 32'hCAFE_F00D);
        for (int i = 0; i < 5; i++) cyc("quiet", 1'b0, 1'b0, 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
